// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared encodings for the memory arbiter: access sizes, ROB
//                index width, FSM states and the IO address window marker.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int         ROB_SIZE_WIDTH = 5;
    localparam logic [1:0] IO_HI_BITS     = 2'b11;

    localparam logic [1:0] STORE_BYTE = 2'b00;
    localparam logic [1:0] STORE_HALF = 2'b01;
    localparam logic [1:0] STORE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Number of byte transfers for an access size; the unused code 11 is
    // treated as a word.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            STORE_BYTE: size_to_len = 3'd1;
            STORE_HALF: size_to_len = 3'd2;
            default:    size_to_len = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : load_extend
//  Description : Combinational byte/half/word zero- or sign-extension of a
//                little-endian assembled load value.
//  Ports       : raw       - assembled bytes (byte 0 in [7:0])
//                size      - 00 byte, 01 half, 10 word
//                is_signed - sign-extend when 1
//                data      - extended result
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (size)
            STORE_BYTE: data = {{24{is_signed & raw[7]}},  raw[7:0]};
            STORE_HALF: data = {{16{is_signed & raw[15]}}, raw[15:0]};
            default:    data = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares the byte-serial RAM port between instruction fetch,
//                LSB loads and committed ROB stores. Splits byte/half/word
//                accesses into byte transfers, stalls on IO back-pressure and
//                aborts speculative reads on flush.
//  Ports       : clk_in/rst_in/rdy_in - clock, async high reset, global enable
//                flush_in             - pipeline flush (aborts reads only)
//                if_*                 - fetch request / word result
//                lsb_*                - load request / extended result + tag
//                rob_st_*             - committed store pulse
//                mem_*                - RAM port, mem_busy to ROB
//                io_buffer_full       - IO write back-pressure
//  Options     : MEM_ARB_RR_EN - round-robin between load and fetch on a tie
//                (default: load always beats fetch)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int         ROB_SIZE_WIDTH = mem_arbiter_pkg::ROB_SIZE_WIDTH,
    parameter logic [1:0] IO_HI_BITS     = mem_arbiter_pkg::IO_HI_BITS
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic                    if_req,
    input  logic [31:0]             if_addr,
    output logic                    if_done,
    output logic [31:0]             if_data,
    input  logic                    lsb_req,
    input  logic [31:0]             lsb_addr,
    input  logic [1:0]              lsb_size,
    input  logic                    lsb_signed,
    input  logic [ROB_SIZE_WIDTH:0] lsb_tag,
    output logic                    lsb_done,
    output logic [31:0]             lsb_data,
    output logic [ROB_SIZE_WIDTH:0] lsb_tag_out,
    input  logic                    rob_st_valid,
    input  logic [1:0]              rob_st_type,
    input  logic [31:0]             rob_st_addr,
    input  logic [31:0]             rob_st_value,
    output logic                    mem_busy,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);

    import mem_arbiter_pkg::*;

    state_t                  r_state;
    logic [31:0]             r_addr;
    logic [2:0]              r_len;
    logic [2:0]              r_iss;      // next read byte index to put on mem_a
    logic [2:0]              r_cap;      // bytes captured (READ) / current byte (WRITE)
    logic                    r_pend;     // mem_din holds byte r_cap this cycle
    logic                    r_is_if;
    logic [1:0]              r_size;
    logic                    r_signed;
    logic [ROB_SIZE_WIDTH:0] r_tag;
    logic [31:0]             r_wval;
    logic [31:0]             r_data;

    logic [31:0] w_raw;
    logic [31:0] w_ext;
    logic [31:0] w_wshift;
    logic [2:0]  w_iss_next;
    logic [2:0]  w_cap_next;
    logic        w_last;
    logic        w_io_stall;
    logic        w_st_io_stall;
    logic        w_take_lsb;

    assign w_iss_next    = r_iss + 3'd1;
    assign w_cap_next    = r_cap + 3'd1;
    assign w_last        = (r_cap == r_len - 3'd1);
    assign w_io_stall    = (r_addr[17:16] == IO_HI_BITS) && io_buffer_full;
    assign w_st_io_stall = (rob_st_addr[17:16] == IO_HI_BITS) && io_buffer_full;
    assign w_wshift      = r_wval >> {w_cap_next[1:0], 3'b000};

    // Collected bytes with the byte arriving this cycle merged in, so the
    // final byte can be returned on the same edge it is captured.
    always_comb begin
        w_raw = r_data;
        w_raw[{r_cap[1:0], 3'b000} +: 8] = mem_din;
    end

`ifdef MEM_ARB_RR_EN
    logic r_last_if;  // fetch won the most recent load/fetch grant
    assign w_take_lsb = lsb_req && (!if_req || r_last_if);
`else
    assign w_take_lsb = lsb_req;
`endif

    load_extend u_load_extend (
        .raw       (w_raw),
        .size      (r_size),
        .is_signed (r_signed),
        .data      (w_ext)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_iss       <= '0;
            r_cap       <= '0;
            r_pend      <= 1'b0;
            r_is_if     <= 1'b0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_tag       <= '0;
            r_wval      <= '0;
            r_data      <= '0;
            if_done     <= 1'b0;
            if_data     <= '0;
            lsb_done    <= 1'b0;
            lsb_data    <= '0;
            lsb_tag_out <= '0;
            mem_busy    <= 1'b0;
            mem_dout    <= '0;
            mem_a       <= '0;
            mem_wr      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_if   <= 1'b0;
`endif
        end else begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            if (!rdy_in) begin
                mem_wr <= 1'b0;
                // The byte in flight is not trusted; point back at the first
                // uncaptured byte so it is re-read once enabled again.
                if (r_state == ST_READ) begin
                    r_pend <= 1'b0;
                    r_iss  <= r_cap;
                    mem_a  <= r_addr + {29'd0, r_cap};
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (rob_st_valid) begin
                            r_state  <= ST_WRITE;
                            mem_busy <= 1'b1;
                            r_addr   <= rob_st_addr;
                            r_len    <= size_to_len(rob_st_type);
                            r_wval   <= rob_st_value;
                            r_cap    <= '0;
                            mem_a    <= rob_st_addr;
                            mem_dout <= rob_st_value[7:0];
                            mem_wr   <= !w_st_io_stall;
                        end else if (!flush_in && (lsb_req || if_req)) begin
                            r_state  <= ST_READ;
                            mem_busy <= 1'b1;
                            r_addr   <= w_take_lsb ? lsb_addr : if_addr;
                            mem_a    <= w_take_lsb ? lsb_addr : if_addr;
                            r_len    <= w_take_lsb ? size_to_len(lsb_size) : 3'd4;
                            r_size   <= w_take_lsb ? lsb_size : STORE_WORD;
                            r_signed <= w_take_lsb & lsb_signed;
                            r_tag    <= lsb_tag;
                            r_is_if  <= !w_take_lsb;
                            r_iss    <= '0;
                            r_cap    <= '0;
                            r_pend   <= 1'b0;
                            r_data   <= '0;
`ifdef MEM_ARB_RR_EN
                            r_last_if <= !w_take_lsb;
`endif
                        end
                    end
                    ST_READ: begin
                        if (flush_in) begin
                            r_state  <= ST_IDLE;
                            mem_busy <= 1'b0;
                            r_pend   <= 1'b0;
                        end else begin
                            // This edge latches mem_a into the RAM.
                            if (r_iss < r_len) begin
                                r_pend <= 1'b1;
                                r_iss  <= w_iss_next;
                                if (w_iss_next < r_len) begin
                                    mem_a <= r_addr + {29'd0, w_iss_next};
                                end
                            end else begin
                                r_pend <= 1'b0;
                            end
                            if (r_pend) begin
                                if (w_last) begin
                                    r_state  <= ST_IDLE;
                                    mem_busy <= 1'b0;
                                    r_pend   <= 1'b0;
                                    if (r_is_if) begin
                                        if_done <= 1'b1;
                                        if_data <= w_raw;
                                    end else begin
                                        lsb_done    <= 1'b1;
                                        lsb_data    <= w_ext;
                                        lsb_tag_out <= r_tag;
                                    end
                                end else begin
                                    r_data <= w_raw;
                                    r_cap  <= w_cap_next;
                                end
                            end
                        end
                    end
                    ST_WRITE: begin
                        // Committed stores ignore flush_in.
                        if (mem_wr) begin
                            if (w_last) begin
                                r_state  <= ST_IDLE;
                                mem_busy <= 1'b0;
                                mem_wr   <= 1'b0;
                            end else begin
                                r_cap    <= w_cap_next;
                                mem_a    <= r_addr + {29'd0, w_cap_next};
                                mem_dout <= w_wshift[7:0];
                                mem_wr   <= !w_io_stall;
                            end
                        end else begin
                            // Current byte held back (IO full or rdy gap).
                            mem_wr <= !w_io_stall;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        mem_busy <= 1'b0;
                        mem_wr   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a byte
//                RAM model (one-cycle read latency) and a write log.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_size;
    logic        lsb_signed;
    logic [5:0]  lsb_tag;
    logic        lsb_done;
    logic [31:0] lsb_data;
    logic [5:0]  lsb_tag_out;
    logic        rob_st_valid;
    logic [1:0]  rob_st_type;
    logic [31:0] rob_st_addr;
    logic [31:0] rob_st_value;
    logic        mem_busy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram [0:262143];
    logic [39:0] wq[$];

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr && rdy_in) begin
            ram[mem_a[17:0]] <= mem_dout;
            wq.push_back({mem_a, mem_dout});
        end
    end

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_signed(lsb_signed), .lsb_tag(lsb_tag), .lsb_done(lsb_done),
        .lsb_data(lsb_data), .lsb_tag_out(lsb_tag_out),
        .rob_st_valid(rob_st_valid), .rob_st_type(rob_st_type),
        .rob_st_addr(rob_st_addr), .rob_st_value(rob_st_value),
        .mem_busy(mem_busy), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick(); tick();
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", mem_busy); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %0h want 0", mem_wr); end
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_a got %0h want 0", mem_a); end
        checks++; if ({if_done, lsb_done} !== 2'b00) begin errors++; $display("FAIL reset_done got %0b want 00", {if_done, lsb_done}); end
        checks++; if (lsb_data !== 32'h0 || if_data !== 32'h0) begin errors++; $display("FAIL reset_data got %0h/%0h want 0/0", lsb_data, if_data); end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        int n;
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        checks++; if (mem_busy !== 1'b1 || mem_a !== 32'h100) begin errors++; $display("FAIL fetch_grant got busy=%0h a=%0h want 1/100", mem_busy, mem_a); end
        tick();
        checks++; if (mem_a !== 32'h101) begin errors++; $display("FAIL fetch_addr1 got %0h want 101", mem_a); end
        n = 1;
        while (!if_done && n < 12) begin tick(); n++; end
        if_req = 1'b0;
        checks++; if (n !== 5) begin errors++; $display("FAIL fetch_latency got %0d want 5", n); end
        checks++; if (if_data !== 32'h44332211) begin errors++; $display("FAIL fetch_data got %0h want 44332211", if_data); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL fetch_idle got %0h want 0", mem_busy); end
        tick();
    endtask

    task automatic test_load();
        int n;
        lsb_req = 1'b1; lsb_addr = 32'h200; lsb_size = 2'b00; lsb_signed = 1'b1; lsb_tag = 6'd7;
        tick();
        n = 0;
        while (!lsb_done && n < 10) begin tick(); n++; end
        lsb_req = 1'b0;
        checks++; if (n !== 2) begin errors++; $display("FAIL load_latency got %0d want 2", n); end
        checks++; if (lsb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL load_sbyte got %0h want ffffff80", lsb_data); end
        checks++; if (lsb_tag_out !== 6'd7) begin errors++; $display("FAIL load_tag got %0d want 7", lsb_tag_out); end
        tick();
        lsb_req = 1'b1; lsb_signed = 1'b0;
        tick();
        n = 0;
        while (!lsb_done && n < 10) begin tick(); n++; end
        lsb_req = 1'b0;
        checks++; if (lsb_data !== 32'h00000080) begin errors++; $display("FAIL load_ubyte got %0h want 80", lsb_data); end
        tick();
        lsb_req = 1'b1; lsb_addr = 32'h203; lsb_size = 2'b01; lsb_signed = 1'b1;
        tick();
        n = 0;
        while (!lsb_done && n < 10) begin tick(); n++; end
        lsb_req = 1'b0;
        checks++; if (lsb_data !== 32'hFFFF9234) begin errors++; $display("FAIL load_shalf got %0h want ffff9234", lsb_data); end
        tick();
    endtask

    task automatic test_store_half();
        wq.delete();
        rob_st_valid = 1'b1; rob_st_type = 2'b01; rob_st_addr = 32'h300; rob_st_value = 32'h0000BEEF;
        tick();
        rob_st_valid = 1'b0;
        checks++; if ({mem_busy, mem_wr, mem_a, mem_dout} !== {1'b1, 1'b1, 32'h300, 8'hEF}) begin errors++; $display("FAIL st_half_b0 got busy=%0h wr=%0h a=%0h d=%0h want 1/1/300/ef", mem_busy, mem_wr, mem_a, mem_dout); end
        tick();
        checks++; if ({mem_busy, mem_wr, mem_a, mem_dout} !== {1'b1, 1'b1, 32'h301, 8'hBE}) begin errors++; $display("FAIL st_half_b1 got busy=%0h wr=%0h a=%0h d=%0h want 1/1/301/be", mem_busy, mem_wr, mem_a, mem_dout); end
        tick();
        checks++; if ({mem_busy, mem_wr} !== 2'b00) begin errors++; $display("FAIL st_half_end got %0b want 00", {mem_busy, mem_wr}); end
        checks++; if (wq.size() !== 2) begin errors++; $display("FAIL st_half_count got %0d want 2", wq.size()); end
        else begin
            checks++; if (wq[0] !== {32'h300, 8'hEF} || wq[1] !== {32'h301, 8'hBE}) begin errors++; $display("FAIL st_half_log got %0h %0h want 300ef 301be", wq[0], wq[1]); end
        end
    endtask

    task automatic test_priority();
        int nl, e_l1, e_l2, e_if;
        logic [31:0] d_l1, d_if;
        logic [5:0]  t_l1;
        nl = 0; e_l1 = -1; e_l2 = -1; e_if = -1; d_l1 = '0; d_if = '0; t_l1 = '0;
        rob_st_valid = 1'b1; rob_st_type = 2'b00; rob_st_addr = 32'h400; rob_st_value = 32'h000000A5;
        lsb_req = 1'b1; lsb_addr = 32'h100; lsb_size = 2'b00; lsb_signed = 1'b0; lsb_tag = 6'd3;
        if_req = 1'b1; if_addr = 32'h500;
        tick();
        rob_st_valid = 1'b0;
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h400) begin errors++; $display("FAIL prio_store_first got wr=%0h a=%0h want 1/400", mem_wr, mem_a); end
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (lsb_done) begin
                nl++;
                if (nl == 1) begin e_l1 = e; d_l1 = lsb_data; t_l1 = lsb_tag_out; lsb_tag = 6'd4; end
                else begin e_l2 = e; lsb_req = 1'b0; end
            end
            if (if_done) begin e_if = e; d_if = if_data; if_req = 1'b0; end
            if (nl == 2 && e_if >= 0) break;
        end
        lsb_req = 1'b0; if_req = 1'b0;
        checks++; if (e_l1 !== 4) begin errors++; $display("FAIL prio_load_second got edge %0d want 4", e_l1); end
        checks++; if (d_l1 !== 32'h11 || t_l1 !== 6'd3) begin errors++; $display("FAIL prio_load_data got %0h tag %0d want 11 tag 3", d_l1, t_l1); end
`ifdef MEM_ARB_RR_EN
        checks++; if (e_if !== 10 || e_l2 !== 13) begin errors++; $display("FAIL prio_rr_tie got if@%0d load@%0d want 10/13", e_if, e_l2); end
`else
        checks++; if (e_l2 !== 7 || e_if !== 13) begin errors++; $display("FAIL prio_fixed_tie got load@%0d if@%0d want 7/13", e_l2, e_if); end
`endif
        checks++; if (d_if !== 32'h04030201) begin errors++; $display("FAIL prio_fetch_data got %0h want 04030201", d_if); end
        checks++; if (ram[18'h400] !== 8'hA5) begin errors++; $display("FAIL prio_store_ram got %0h want a5", ram[18'h400]); end
        tick();
    endtask

    task automatic test_flush();
        bit seen;
        flush_in = 1'b1; if_req = 1'b1; if_addr = 32'h500;
        tick();
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL flush_grant_block got busy=%0h want 0", mem_busy); end
        flush_in = 1'b0;
        tick(); tick(); tick();
        flush_in = 1'b1;
        tick();
        checks++; if (mem_busy !== 1'b0 || if_done !== 1'b0) begin errors++; $display("FAIL flush_read_abort got busy=%0h done=%0h want 0/0", mem_busy, if_done); end
        flush_in = 1'b0; if_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (if_done) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_done got %0h want 0", seen); end
        wq.delete();
        rob_st_valid = 1'b1; rob_st_type = 2'b10; rob_st_addr = 32'h600; rob_st_value = 32'hDEADBEEF;
        flush_in = 1'b1;
        tick();
        rob_st_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        flush_in = 1'b0;
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL flush_store_end got busy=%0h want 0", mem_busy); end
        checks++; if (wq.size() !== 4) begin errors++; $display("FAIL flush_store_count got %0d want 4", wq.size()); end
        else begin
            checks++; if (wq[0] !== {32'h600, 8'hEF} || wq[1] !== {32'h601, 8'hBE} || wq[2] !== {32'h602, 8'hAD} || wq[3] !== {32'h603, 8'hDE})
                begin errors++; $display("FAIL flush_store_log got %0h %0h %0h %0h want 600ef 601be 602ad 603de", wq[0], wq[1], wq[2], wq[3]); end
        end
        tick();
    endtask

    task automatic test_io_stall();
        int viol, e_end;
        wq.delete(); viol = 0; e_end = -1;
        io_buffer_full = 1'b1;
        rob_st_valid = 1'b1; rob_st_type = 2'b10; rob_st_addr = 32'h30000; rob_st_value = 32'h11223344;
        tick();
        rob_st_valid = 1'b0;
        if (mem_wr) viol++;
        tick(); if (mem_wr) viol++;
        tick(); if (mem_wr) viol++;
        io_buffer_full = 1'b0;
        for (int e = 3; e <= 20; e++) begin
            tick();
            if (!mem_busy) begin e_end = e; break; end
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL io_wr_while_full got %0d want 0", viol); end
        checks++; if (e_end !== 7) begin errors++; $display("FAIL io_end_edge got %0d want 7", e_end); end
        checks++; if (wq.size() !== 4) begin errors++; $display("FAIL io_count got %0d want 4", wq.size()); end
        else begin
            checks++; if (wq[0] !== {32'h30000, 8'h44} || wq[1] !== {32'h30001, 8'h33} || wq[2] !== {32'h30002, 8'h22} || wq[3] !== {32'h30003, 8'h11})
                begin errors++; $display("FAIL io_log got %0h %0h %0h %0h want 3000044 3000133 3000222 3000311", wq[0], wq[1], wq[2], wq[3]); end
        end
        tick();
    endtask

    task automatic test_rdy();
        int e_end, n;
        wq.delete(); e_end = -1;
        rob_st_valid = 1'b1; rob_st_type = 2'b01; rob_st_addr = 32'h700; rob_st_value = 32'h0000CAFE;
        tick();
        rob_st_valid = 1'b0; rdy_in = 1'b0;
        tick();
        checks++; if (mem_wr !== 1'b0 || mem_busy !== 1'b1) begin errors++; $display("FAIL rdy_wr_freeze got wr=%0h busy=%0h want 0/1", mem_wr, mem_busy); end
        rdy_in = 1'b1;
        for (int e = 2; e <= 12; e++) begin
            tick();
            if (!mem_busy) begin e_end = e; break; end
        end
        checks++; if (e_end !== 4) begin errors++; $display("FAIL rdy_wr_end got %0d want 4", e_end); end
        checks++; if (wq.size() !== 2) begin errors++; $display("FAIL rdy_wr_count got %0d want 2", wq.size()); end
        else begin
            checks++; if (wq[0] !== {32'h700, 8'hFE} || wq[1] !== {32'h701, 8'hCA}) begin errors++; $display("FAIL rdy_wr_log got %0h %0h want 700fe 701ca", wq[0], wq[1]); end
        end
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        tick(); tick(); tick();
        rdy_in = 1'b0;
        tick(); tick();
        rdy_in = 1'b1;
        n = 4;
        while (!if_done && n < 20) begin tick(); n++; end
        if_req = 1'b0;
        checks++; if (n !== 8) begin errors++; $display("FAIL rdy_rd_latency got %0d want 8", n); end
        checks++; if (if_data !== 32'h44332211) begin errors++; $display("FAIL rdy_rd_data got %0h want 44332211", if_data); end
        tick();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_signed = 1'b0; lsb_tag = '0;
        rob_st_valid = 1'b0; rob_st_type = '0; rob_st_addr = '0; rob_st_value = '0;
        io_buffer_full = 1'b0;
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h100] = 8'h11; ram[18'h101] = 8'h22; ram[18'h102] = 8'h33; ram[18'h103] = 8'h44;
        ram[18'h200] = 8'h80; ram[18'h203] = 8'h34; ram[18'h204] = 8'h92;
        ram[18'h500] = 8'h01; ram[18'h501] = 8'h02; ram[18'h502] = 8'h03; ram[18'h503] = 8'h04;
        test_reset();
        test_fetch();
        test_load();
        test_store_half();
        test_priority();
        test_flush();
        test_io_stall();
        test_rdy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
